l15_port_arbiter: RTL and testbench

L15_PORT_ARBITER -- requirements
Module: l15_port_arbiter

---
 rtl/l15_arb_pkg.sv | 24 ++
 rtl/l15_port_arbiter_if.sv | 50 +++++
 rtl/l15_arb_pick.sv | 14 +
 rtl/l15_port_arbiter.sv | 127 ++++++++++++
 tb/tb_l15_port_arbiter.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/l15_arb_pkg.sv
// Shared types and L1.5 field widths for the two-requester L1.5 port arbiter.
package l15_arb_pkg;
  localparam int RQTYPE_W = 5;
  localparam int SIZE_W   = 3;
  localparam int ADDR_W   = 40;
  localparam int DATA_W   = 64;
  localparam int RTYPE_W  = 4;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
  typedef enum logic {OWN_INSTR = 1'b0, OWN_MEM = 1'b1} owner_t;

  typedef struct packed {
    logic [RQTYPE_W-1:0] rqtype;
    logic [SIZE_W-1:0]   size;
    logic [ADDR_W-1:0]   address;
    logic [DATA_W-1:0]   data;
  } l15_req_t;

  typedef struct packed {
    logic [DATA_W-1:0]  data_0;
    logic [DATA_W-1:0]  data_1;
    logic [RTYPE_W-1:0] returntype;
  } l15_rsp_t;
endpackage

// File: rtl/l15_port_arbiter_if.sv
// Requester-side and L1.5-port-side signals of the arbiter; slave is the arbiter's view.
interface l15_port_arbiter_if;
  import l15_arb_pkg::*;

  logic [RQTYPE_W-1:0] i_rqtype, m_rqtype;
  logic [SIZE_W-1:0]   i_size, m_size;
  logic [ADDR_W-1:0]   i_address, m_address;
  logic [DATA_W-1:0]   i_data, m_data;
  logic                i_val, m_val, i_req_ack, m_req_ack;

  logic                i_ack, m_ack, i_header_ack, m_header_ack, i_rsp_val, m_rsp_val;
  logic [DATA_W-1:0]   i_data_0, i_data_1, m_data_0, m_data_1;
  logic [RTYPE_W-1:0]  i_returntype, m_returntype;

  logic [RQTYPE_W-1:0] transducer_l15_rqtype;
  logic [SIZE_W-1:0]   transducer_l15_size;
  logic [ADDR_W-1:0]   transducer_l15_address;
  logic [DATA_W-1:0]   transducer_l15_data;
  logic                transducer_l15_val, transducer_l15_req_ack;

  logic                l15_transducer_ack, l15_transducer_header_ack, l15_transducer_val;
  logic [DATA_W-1:0]   l15_transducer_data_0, l15_transducer_data_1;
  logic [RTYPE_W-1:0]  l15_transducer_returntype;

  logic                grant_i, grant_m, busy, err_stray;

  modport slave (
    input  i_rqtype, m_rqtype, i_size, m_size, i_address, m_address, i_data, m_data,
           i_val, m_val, i_req_ack, m_req_ack,
           l15_transducer_ack, l15_transducer_header_ack, l15_transducer_val,
           l15_transducer_data_0, l15_transducer_data_1, l15_transducer_returntype,
    output i_ack, m_ack, i_header_ack, m_header_ack, i_rsp_val, m_rsp_val,
           i_data_0, i_data_1, m_data_0, m_data_1, i_returntype, m_returntype,
           transducer_l15_rqtype, transducer_l15_size, transducer_l15_address,
           transducer_l15_data, transducer_l15_val, transducer_l15_req_ack,
           grant_i, grant_m, busy, err_stray
  );

  modport master (
    output i_rqtype, m_rqtype, i_size, m_size, i_address, m_address, i_data, m_data,
           i_val, m_val, i_req_ack, m_req_ack,
           l15_transducer_ack, l15_transducer_header_ack, l15_transducer_val,
           l15_transducer_data_0, l15_transducer_data_1, l15_transducer_returntype,
    input  i_ack, m_ack, i_header_ack, m_header_ack, i_rsp_val, m_rsp_val,
           i_data_0, i_data_1, m_data_0, m_data_1, i_returntype, m_returntype,
           transducer_l15_rqtype, transducer_l15_size, transducer_l15_address,
           transducer_l15_data, transducer_l15_val, transducer_l15_req_ack,
           grant_i, grant_m, busy, err_stray
  );
endinterface

// File: rtl/l15_arb_pick.sv
// Two-way round-robin pick: MEM wins a tie unless it won the previous grant.
module l15_arb_pick
  import l15_arb_pkg::*;
(
  input  logic   i_val,
  input  logic   m_val,
  input  owner_t last_grant,
  output owner_t grant
);
  always_comb begin
    grant = OWN_INSTR;
    if (m_val && (!i_val || last_grant != OWN_MEM)) grant = OWN_MEM;
  end
endmodule

// File: rtl/l15_port_arbiter.sv
// Shares one L1.5 transducer port between the instruction-fetch and data-memory requesters.
module l15_port_arbiter
  import l15_arb_pkg::*;
(
  input  logic clk,
  input  logic nrst,
  l15_port_arbiter_if.slave bus
);
  state_t   state, state_nxt;
  owner_t   owner, last_grant, pick_gnt;
  logic     err_stray_q;
  logic     own_i, own_m, own_val, own_req_ack, any_val;
  logic     ack_r, hdr_r, rsp_r, fields_en, port_val, port_req_ack, stray;
  l15_req_t req_i, req_m, req_o;
  l15_rsp_t rsp_in, rsp_o;

  l15_arb_pick u_pick (
    .i_val      (bus.i_val),
    .m_val      (bus.m_val),
    .last_grant (last_grant),
    .grant      (pick_gnt)
  );

  assign any_val     = bus.i_val | bus.m_val;
  assign own_i       = (owner == OWN_INSTR);
  assign own_m       = (owner == OWN_MEM);
  assign own_val     = own_m ? bus.m_val : bus.i_val;
  assign own_req_ack = own_m ? bus.m_req_ack : bus.i_req_ack;

  assign req_i  = '{bus.i_rqtype, bus.i_size, bus.i_address, bus.i_data};
  assign req_m  = '{bus.m_rqtype, bus.m_size, bus.m_address, bus.m_data};
  assign rsp_in = '{bus.l15_transducer_data_0, bus.l15_transducer_data_1,
                    bus.l15_transducer_returntype};

  always_comb begin
    state_nxt    = state;
    ack_r        = 1'b0;
    hdr_r        = 1'b0;
    rsp_r        = 1'b0;
    fields_en    = 1'b0;
    port_val     = 1'b0;
    port_req_ack = 1'b0;
    stray        = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_val) state_nxt = S_REQ;
        stray = bus.l15_transducer_val;
      end
      S_REQ: begin
        fields_en = 1'b1;
        port_val  = own_val;
        if (!own_val) begin
          // Abort: requester withdrew, nothing is routed back to it.
          state_nxt = S_IDLE;
          stray     = bus.l15_transducer_val;
        end else begin
          hdr_r = bus.l15_transducer_header_ack;
          if (bus.l15_transducer_ack) begin
            ack_r     = 1'b1;
            state_nxt = S_RESP;
            if (bus.l15_transducer_val) begin
              rsp_r        = 1'b1;
              port_req_ack = own_req_ack;
              if (own_req_ack) state_nxt = S_IDLE;
            end
          end else begin
            stray = bus.l15_transducer_val;
          end
        end
      end
      S_RESP: begin
        fields_en    = 1'b1;
        rsp_r        = 1'b1;
        port_req_ack = own_req_ack;
        if (bus.l15_transducer_val && own_req_ack) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // A response nobody asked for is drained so the port does not stall.
    if (stray) port_req_ack = 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= S_IDLE;
      owner       <= OWN_INSTR;
      last_grant  <= OWN_INSTR;
      err_stray_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      err_stray_q <= err_stray_q | stray;
      if (state == S_IDLE && any_val) begin
        owner      <= pick_gnt;
        last_grant <= pick_gnt;
      end
    end
  end

  assign req_o = fields_en ? (own_m ? req_m : req_i) : '0;
  assign rsp_o = rsp_r ? rsp_in : '0;

  assign bus.transducer_l15_rqtype  = req_o.rqtype;
  assign bus.transducer_l15_size    = req_o.size;
  assign bus.transducer_l15_address = req_o.address;
  assign bus.transducer_l15_data    = req_o.data;
  assign bus.transducer_l15_val     = port_val;
  // Gated by nrst so a response arriving during reset is not drained.
  assign bus.transducer_l15_req_ack = port_req_ack & nrst;

  assign bus.i_ack        = own_i & ack_r;
  assign bus.m_ack        = own_m & ack_r;
  assign bus.i_header_ack = own_i & hdr_r;
  assign bus.m_header_ack = own_m & hdr_r;
  assign bus.i_rsp_val    = own_i & rsp_r & bus.l15_transducer_val;
  assign bus.m_rsp_val    = own_m & rsp_r & bus.l15_transducer_val;
  assign bus.i_data_0     = own_i ? rsp_o.data_0 : '0;
  assign bus.i_data_1     = own_i ? rsp_o.data_1 : '0;
  assign bus.i_returntype = own_i ? rsp_o.returntype : '0;
  assign bus.m_data_0     = own_m ? rsp_o.data_0 : '0;
  assign bus.m_data_1     = own_m ? rsp_o.data_1 : '0;
  assign bus.m_returntype = own_m ? rsp_o.returntype : '0;

  assign bus.busy      = (state != S_IDLE);
  assign bus.grant_i   = bus.busy & own_i;
  assign bus.grant_m   = bus.busy & own_m;
  assign bus.err_stray = err_stray_q;
endmodule

// File: tb/tb_l15_port_arbiter.sv
// Directed bench for l15_port_arbiter: grants, routing, abort, stray drain, async reset.
module tb_l15_port_arbiter;
  import l15_arb_pkg::*;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  l15_port_arbiter_if bus ();

  l15_port_arbiter dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge; inputs change and checks happen here.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_port();
    bus.l15_transducer_ack        = 1'b0;
    bus.l15_transducer_header_ack = 1'b0;
    bus.l15_transducer_val        = 1'b0;
    bus.l15_transducer_data_0     = '0;
    bus.l15_transducer_data_1     = '0;
    bus.l15_transducer_returntype = '0;
    bus.i_req_ack                 = 1'b0;
    bus.m_req_ack                 = 1'b0;
  endtask

  initial begin
    bus.i_rqtype = 5'h00; bus.i_size = 3'd0; bus.i_address = '0; bus.i_data = '0; bus.i_val = 1'b0;
    bus.m_rqtype = 5'h00; bus.m_size = 3'd0; bus.m_address = '0; bus.m_data = '0; bus.m_val = 1'b0;
    clr_port();

    // Reset state
    #3;
    chk("rst_busy", bus.busy, 0);
    chk("rst_grant_i", bus.grant_i, 0);
    chk("rst_grant_m", bus.grant_m, 0);
    chk("rst_err", bus.err_stray, 0);
    chk("rst_pval", bus.transducer_l15_val, 0);
    #10 nrst = 1'b1;
    tick();

    // MEM-only transaction through REQ and RESP
    bus.m_val = 1'b1; bus.m_address = 40'h0080000010; bus.m_rqtype = 5'h01; bus.m_size = 3'd3;
    #1 chk("m_idle_grant", bus.grant_m, 0);
    tick();
    chk("m_grant", bus.grant_m, 1);
    chk("m_busy", bus.busy, 1);
    chk("m_addr", bus.transducer_l15_address, 64'h80000010);
    chk("m_rqtype", bus.transducer_l15_rqtype, 5'h01);
    chk("m_pval", bus.transducer_l15_val, 1);
    chk("m_ack_early", bus.m_ack, 0);
    bus.l15_transducer_ack = 1'b1; bus.l15_transducer_header_ack = 1'b1;
    #1 chk("m_ack", bus.m_ack, 1);
    chk("m_hdr_ack", bus.m_header_ack, 1);
    chk("m_i_ack", bus.i_ack, 0);
    tick();
    bus.l15_transducer_ack = 1'b0; bus.l15_transducer_header_ack = 1'b0; bus.m_val = 1'b0;
    #1 chk("m_resp_busy", bus.busy, 1);
    chk("m_resp_pval", bus.transducer_l15_val, 0);
    bus.l15_transducer_val = 1'b1; bus.l15_transducer_data_0 = 64'h0123456789ABCDEF;
    bus.l15_transducer_returntype = 4'h2;
    #1 chk("m_rsp_val", bus.m_rsp_val, 1);
    chk("m_data0", bus.m_data_0, 64'h0123456789ABCDEF);
    chk("m_rtype", bus.m_returntype, 4'h2);
    chk("m_reqack_lo", bus.transducer_l15_req_ack, 0);
    tick();
    chk("m_wait_busy", bus.busy, 1);
    bus.m_req_ack = 1'b1;
    #1 chk("m_reqack_hi", bus.transducer_l15_req_ack, 1);
    tick();
    clr_port();
    #1 chk("m_done_busy", bus.busy, 0);
    chk("m_done_grant", bus.grant_m, 0);

    // INSTR owner in RESP: data reaches INSTR only
    bus.i_val = 1'b1; bus.i_address = 40'h0000001000;
    tick();
    chk("i_grant", bus.grant_i, 1);
    bus.l15_transducer_ack = 1'b1;
    tick();
    bus.l15_transducer_ack = 1'b0; bus.i_val = 1'b0;
    bus.l15_transducer_val = 1'b1; bus.l15_transducer_data_0 = 64'hDEADBEEF00000013;
    bus.l15_transducer_data_1 = 64'h5555AAAA5555AAAA; bus.l15_transducer_returntype = 4'h1;
    #1 chk("i_data0", bus.i_data_0, 64'hDEADBEEF00000013);
    chk("i_data1", bus.i_data_1, 64'h5555AAAA5555AAAA);
    chk("i_rsp_val", bus.i_rsp_val, 1);
    chk("i_m_data0", bus.m_data_0, 0);
    chk("i_m_rsp_val", bus.m_rsp_val, 0);
    bus.i_req_ack = 1'b1;
    tick();
    clr_port();
    #1 chk("i_done_busy", bus.busy, 0);

    // Both valid after reset: MEM, INSTR, MEM, INSTR; ack+response in the REQ cycle
    nrst = 1'b0;
    bus.i_val = 1'b1; bus.m_val = 1'b1;
    #3 nrst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_grant_m", bus.grant_m, (k % 2 == 0) ? 1 : 0);
      chk("rr_grant_i", bus.grant_i, (k % 2 == 0) ? 0 : 1);
      bus.l15_transducer_ack = 1'b1; bus.l15_transducer_val = 1'b1;
      bus.i_req_ack = 1'b1; bus.m_req_ack = 1'b1;
      #1 chk("rr_rsp_m", bus.m_rsp_val, (k % 2 == 0) ? 1 : 0);
      tick();
      clr_port();
      #1 chk("rr_idle", bus.busy, 0);
    end
    bus.i_val = 1'b0; bus.m_val = 1'b0;

    // MEM abort in REQ: no ack ever routed
    bus.m_val = 1'b1;
    tick();
    chk("ab_grant", bus.grant_m, 1);
    bus.m_val = 1'b0; bus.l15_transducer_ack = 1'b1;
    #1 chk("ab_m_ack", bus.m_ack, 0);
    chk("ab_pval", bus.transducer_l15_val, 0);
    tick();
    chk("ab_m_ack2", bus.m_ack, 0);
    bus.l15_transducer_ack = 1'b0;
    #1 chk("ab_idle", bus.busy, 0);

    // Stray response in IDLE
    chk("st_err0", bus.err_stray, 0);
    bus.l15_transducer_val = 1'b1;
    #1 chk("st_drain", bus.transducer_l15_req_ack, 1);
    tick();
    bus.l15_transducer_val = 1'b0;
    #1 chk("st_err1", bus.err_stray, 1);
    tick();
    chk("st_err_hold", bus.err_stray, 1);

    // Async reset in RESP, then a pending INSTR request is granted
    bus.i_val = 1'b1; bus.i_address = 40'h00000ABCD0;
    tick();
    bus.l15_transducer_ack = 1'b1;
    tick();
    bus.l15_transducer_ack = 1'b0;
    bus.l15_transducer_val = 1'b1; bus.l15_transducer_data_0 = 64'h1111;
    #1 chk("rr_pre_rsp", bus.i_rsp_val, 1);
    nrst = 1'b0;
    #1 chk("ar_rsp", bus.i_rsp_val, 0);
    chk("ar_data0", bus.i_data_0, 0);
    chk("ar_busy", bus.busy, 0);
    chk("ar_grant", bus.grant_i, 0);
    chk("ar_reqack", bus.transducer_l15_req_ack, 0);
    chk("ar_err", bus.err_stray, 0);
    bus.l15_transducer_val = 1'b0; bus.l15_transducer_data_0 = '0;
    #2 nrst = 1'b1;
    tick();
    chk("ar_regrant", bus.grant_i, 1);
    chk("ar_pval", bus.transducer_l15_val, 1);
    chk("ar_addr", bus.transducer_l15_address, 64'hABCD0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
